// File: rtl/perceptron_core.sv
// Trainable single-layer perceptron: sequential MAC over N_INPUTS signed inputs
// plus bias, valid/ready in and out, perceptron-rule weight update on a mistake.
module perceptron_core #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 12,
    parameter int ACC_W    = 24,
    parameter int LR_SHIFT = 2,
    parameter int ERR_W    = 16
) (
    input  logic                         clk,
    input  logic                         nRst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_INPUTS*DATA_W-1:0]   in_data,
    input  logic                         in_train,
    input  logic                         in_target,
    input  logic                         wt_clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_class,
    output logic signed [ACC_W-1:0]      out_sum,
    output logic [ERR_W-1:0]             err_count
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    localparam int SUM_W  = ((WEIGHT_W > DATA_W) ? WEIGHT_W : DATA_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_UPDATE} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic signed [DATA_W-1:0]     r_x [N_INPUTS];
    logic signed [WEIGHT_W-1:0]   r_w [N_INPUTS];
    logic signed [WEIGHT_W-1:0]   r_bias;
    logic signed [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]             r_idx;
    logic                         r_train;
    logic                         r_target;
    logic                         r_out_class;
    logic signed [ACC_W-1:0]      r_out_sum;
    logic [ERR_W-1:0]             r_err;

    logic [IDX_W-1:0]             w_widx;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_acc_nxt;
    logic signed [DATA_W-1:0]     w_delta;
    logic signed [SUM_W-1:0]      w_wsum;
    logic signed [SUM_W-1:0]      w_bsum;
    logic                         w_accept;
    logic                         w_last_in;
    logic                         w_last_upd;
    logic                         w_mistake;

    // Clamp a widened weight/bias sum back into the signed WEIGHT_W range.
    function automatic logic signed [WEIGHT_W-1:0] sat_w(input logic signed [SUM_W-1:0] v);
        if ((&v[SUM_W-1:WEIGHT_W-1]) || !(|v[SUM_W-1:WEIGHT_W-1]))
            return v[WEIGHT_W-1:0];
        else if (v[SUM_W-1])
            return {1'b1, {(WEIGHT_W-1){1'b0}}};
        else
            return {1'b0, {(WEIGHT_W-1){1'b1}}};
    endfunction

    assign in_ready   = (r_state == S_IDLE) && !wt_clear;
    assign out_valid  = (r_state == S_OUT);
    assign out_sum    = r_out_sum;
    assign out_class  = r_out_class;
    assign err_count  = r_err;

    assign w_accept   = in_valid && in_ready;
    assign w_widx     = r_idx[IDX_W-1:0];
    assign w_last_in  = (r_idx == CNT_W'(N_INPUTS - 1));
    assign w_last_upd = (r_idx == CNT_W'(N_INPUTS));
    assign w_mistake  = r_train && (r_out_class != r_target);

    assign w_prod    = PROD_W'(r_w[w_widx]) * PROD_W'(r_x[w_widx]);
    assign w_acc_nxt = r_acc + ACC_W'(w_prod);
    assign w_delta   = r_x[w_widx] >>> LR_SHIFT;
    assign w_wsum    = r_target ? (SUM_W'(r_w[w_widx]) + SUM_W'(w_delta))
                                : (SUM_W'(r_w[w_widx]) - SUM_W'(w_delta));
    assign w_bsum    = r_target ? (SUM_W'(r_bias) + SUM_W'(1))
                                : (SUM_W'(r_bias) - SUM_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_MAC;
            S_MAC:    if (w_last_in) w_state_nxt = S_OUT;
            S_OUT:    if (out_ready) w_state_nxt = w_mistake ? S_UPDATE : S_IDLE;
            S_UPDATE: if (w_last_upd) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Control, weights and result registers: cleared by reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_bias      <= '0;
            r_out_sum   <= '0;
            r_out_class <= 1'b0;
            r_err       <= '0;
            for (int i = 0; i < N_INPUTS; i++) r_w[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (wt_clear) begin
                        r_bias <= '0;
                        for (int i = 0; i < N_INPUTS; i++) r_w[i] <= '0;
                    end else if (in_valid) begin
                        r_idx <= '0;
                    end
                end
                S_MAC: begin
                    if (w_last_in) begin
                        r_idx       <= '0;
                        r_out_sum   <= w_acc_nxt;
                        r_out_class <= ~w_acc_nxt[ACC_W-1];
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready && w_mistake && (r_err != '1))
                        r_err <= r_err + ERR_W'(1);
                end
                S_UPDATE: begin
                    // Weights first in index order, bias on the final cycle.
                    if (w_last_upd)
                        r_bias <= sat_w(w_bsum);
                    else
                        r_w[w_widx] <= sat_w(w_wsum);
                    r_idx <= r_idx + CNT_W'(1);
                end
                default: r_idx <= '0;
            endcase
        end
    end

    // Sample latch and accumulator: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < N_INPUTS; i++) r_x[i] <= in_data[i*DATA_W +: DATA_W];
            r_train  <= in_train;
            r_target <= in_target;
            r_acc    <= ACC_W'(r_bias);
        end else if (r_state == S_MAC) begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule

// File: tb/tb_perceptron_core.sv
// Scoreboard bench for perceptron_core: a default instance (4 inputs) and a
// small saturating instance (2 inputs, 8-bit weights, no learning-rate shift).
module tb_perceptron_core;

    localparam int AW = 24;
    localparam int EW = 16;

    typedef struct {
        longint sum;
        bit     cls;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 nRst = 1'b1;
    logic                 in_valid_a  [2];
    logic                 in_ready_a  [2];
    logic                 in_train_a  [2];
    logic                 in_target_a [2];
    logic                 wt_clear_a  [2];
    logic                 out_valid_a [2];
    logic                 out_ready_a [2];
    logic                 out_class_a [2];
    logic signed [AW-1:0] out_sum_a   [2];
    logic [EW-1:0]        err_a       [2];
    logic [31:0]          in_data0;
    logic [15:0]          in_data1;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   issued [2] = '{0, 0};
    int   accepts[2] = '{0, 0};
    int   acc_cyc[2] = '{0, 0};
    bit   hold   [2] = '{1'b0, 1'b0};

    int   mw [2][4];
    int   mb [2];
    int   merr [2];
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    bit          prev_v [2];
    bit          prev_r [2];
    longint      prev_sum [2];
    bit          prev_cls [2];

    perceptron_core #(.N_INPUTS(4), .DATA_W(8), .WEIGHT_W(12), .ACC_W(24),
                      .LR_SHIFT(2), .ERR_W(16)) u_dut0 (
        .clk(clk), .nRst(nRst),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_data(in_data0),
        .in_train(in_train_a[0]), .in_target(in_target_a[0]), .wt_clear(wt_clear_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .out_class(out_class_a[0]), .out_sum(out_sum_a[0]), .err_count(err_a[0])
    );

    perceptron_core #(.N_INPUTS(2), .DATA_W(8), .WEIGHT_W(8), .ACC_W(24),
                      .LR_SHIFT(0), .ERR_W(16)) u_dut1 (
        .clk(clk), .nRst(nRst),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_data(in_data1),
        .in_train(in_train_a[1]), .in_target(in_target_a[1]), .wt_clear(wt_clear_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .out_class(out_class_a[1]), .out_sum(out_sum_a[1]), .err_count(err_a[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ni(int d);  return (d == 0) ? 4 : 2;  endfunction
    function automatic int wb(int d);  return (d == 0) ? 12 : 8; endfunction
    function automatic int ls(int d);  return (d == 0) ? 2 : 0;  endfunction
    function automatic int rx();       return int'($urandom_range(0, 255)) - 128; endfunction

    function automatic int clampw(int v, int bits);
        int hi = (1 << (bits - 1)) - 1;
        int lo = -(1 << (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint wrap_acc(longint v);
        longint m = v & 64'sd16777215;
        if (m >= 64'sd8388608) m = m - 64'sd16777216;
        return m;
    endfunction

    task automatic chk(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) mw[d][i] = 0;
            mb[d] = 0;
            merr[d] = 0;
        end
    endtask

    task automatic drive_x(int d, int x0, int x1, int x2, int x3);
        if (d == 0) in_data0 = {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
        else        in_data1 = {8'(x1), 8'(x0)};
    endtask

    // Issue one sample: model predicts the result and applies the learning rule.
    task automatic send(int d, int x0, int x1, int x2, int x3, bit tr, bit tg);
        int     x[4];
        int     n = 0;
        longint s;
        exp_t   e;
        x = '{x0, x1, x2, x3};
        while (!in_ready_a[d] && n < 300) begin @(posedge clk); #1; n++; end
        if (!in_ready_a[d]) begin fail_now($sformatf("d%0d_send_ready", d)); return; end
        s = mb[d];
        for (int i = 0; i < ni(d); i++) s += longint'(mw[d][i]) * longint'(x[i]);
        s = wrap_acc(s);
        e.sum = s;
        e.cls = (s >= 0);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        issued[d]++;
        if (tr && (e.cls != tg)) begin
            merr[d] = (merr[d] == 65535) ? 65535 : merr[d] + 1;
            for (int i = 0; i < ni(d); i++) begin
                int dl = x[i] >>> ls(d);
                mw[d][i] = clampw(tg ? mw[d][i] + dl : mw[d][i] - dl, wb(d));
            end
            mb[d] = clampw(tg ? mb[d] + 1 : mb[d] - 1, wb(d));
        end
        drive_x(d, x0, x1, x2, x3);
        in_train_a[d]  = tr;
        in_target_a[d] = tg;
        in_valid_a[d]  = 1'b1;
        @(posedge clk); #1;
        in_valid_a[d]  = 1'b0;
    endtask

    task automatic wait_idle(int d);
        int n = 0;
        while (!in_ready_a[d] && n < 300) begin @(posedge clk); #1; n++; end
        if (!in_ready_a[d]) fail_now($sformatf("d%0d_wait_idle", d));
        chk($sformatf("d%0d_err_count", d), err_a[d], merr[d]);
    endtask

    // Clear requested together with a sample offer: clear wins, nothing accepted.
    task automatic do_clear(int d);
        wt_clear_a[d] = 1'b1;
        in_valid_a[d] = 1'b1;
        drive_x(d, rx(), rx(), rx(), rx());
        #1;
        chk($sformatf("d%0d_ready_during_clear", d), in_ready_a[d], 0);
        @(posedge clk); #1;
        wt_clear_a[d] = 1'b0;
        in_valid_a[d] = 1'b0;
        for (int i = 0; i < 4; i++) mw[d][i] = 0;
        mb[d] = 0;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_out_valid", d), out_valid_a[d], 0);
            chk($sformatf("d%0d_rst_out_sum", d), out_sum_a[d], 0);
            chk($sformatf("d%0d_rst_out_class", d), out_class_a[d], 0);
            chk($sformatf("d%0d_rst_err", d), err_a[d], 0);
            chk($sformatf("d%0d_rst_in_ready", d), in_ready_a[d], 1);
        end
        @(negedge clk);
        nRst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Consumer side: random backpressure unless a stall is requested.
    initial begin
        out_ready_a[0] = 1'b0;
        out_ready_a[1] = 1'b0;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                out_ready_a[d] = hold[d] ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency, stability under stall, and scoreboard compare.
    always @(negedge clk) begin
        if (!nRst) begin
            for (int d = 0; d < 2; d++) begin prev_v[d] = 1'b0; prev_r[d] = 1'b0; end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid_a[d] && !prev_v[d])
                    chk($sformatf("d%0d_latency", d), cyc - acc_cyc[d], ni(d));
                if (out_valid_a[d] && prev_v[d] && !prev_r[d]) begin
                    chk($sformatf("d%0d_stable_sum", d), out_sum_a[d], prev_sum[d]);
                    chk($sformatf("d%0d_stable_class", d), out_class_a[d], prev_cls[d]);
                end
                if (out_valid_a[d] && out_ready_a[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL d%0d_unexpected_output: got sum=%0d, expected no output",
                                 d, out_sum_a[d]);
                    end else begin
                        mon_e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("d%0d_out_sum", d), out_sum_a[d], mon_e.sum);
                        chk($sformatf("d%0d_out_class", d), out_class_a[d], mon_e.cls);
                    end
                end
                if (in_valid_a[d] && in_ready_a[d]) begin
                    accepts[d]++;
                    acc_cyc[d] = cyc + 1;
                end
                prev_v[d]   = out_valid_a[d];
                prev_r[d]   = out_ready_a[d];
                prev_sum[d] = out_sum_a[d];
                prev_cls[d] = out_class_a[d];
            end
        end
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            in_valid_a[d] = 1'b0; in_train_a[d] = 1'b0; in_target_a[d] = 1'b0;
            wt_clear_a[d] = 1'b0;
        end
        in_data0 = '0;
        in_data1 = '0;
        model_reset();
        #2;
        do_reset();

        // Inference on zero weights.
        send(0, 10, 20, -5, 3, 1'b0, 1'b0);
        wait_idle(0);
        send(0, 10, 20, -5, 3, 1'b0, 1'b0);
        wait_idle(0);

        // Training mistake, then inference with the learned weights.
        send(0, 16, -8, 4, 0, 1'b1, 1'b0);
        wait_idle(0);
        send(0, 16, -8, 4, 0, 1'b0, 1'b0);
        wait_idle(0);

        // Stall the result for 10 cycles while offering spurious samples.
        hold[0] = 1'b1;
        send(0, 1, 2, 3, 4, 1'b0, 1'b0);
        n = 0;
        while (!out_valid_a[0] && n < 50) begin @(posedge clk); #1; n++; end
        if (!out_valid_a[0]) fail_now("stall_wait_valid");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid_a[0] = 1'($urandom_range(0, 1));
            drive_x(0, rx(), rx(), rx(), rx());
            chk("stall_in_ready", in_ready_a[0], 0);
            chk("stall_out_valid", out_valid_a[0], 1);
        end
        in_valid_a[0] = 1'b0;
        hold[0] = 1'b0;
        wait_idle(0);

        // Saturation on the small instance.
        send(1, 100, 100, 0, 0, 1'b1, 1'b0);
        wait_idle(1);
        send(1, 100, -100, 0, 0, 1'b1, 1'b1);
        wait_idle(1);
        send(1, 0, 1, 0, 0, 1'b0, 1'b0);
        wait_idle(1);

        // Clear colliding with a sample offer, then inference on cleared weights.
        send(0, 50, -60, 70, -80, 1'b1, 1'b1);
        wait_idle(0);
        do_clear(0);
        send(0, 33, -17, 90, -2, 1'b0, 1'b0);
        wait_idle(0);

        // Reset during MAC.
        send(0, 5, 6, 7, 8, 1'b0, 1'b0);
        chk("busy_mac_in_ready", in_ready_a[0], 0);
        void'(q0.pop_back());
        accepts[0]--;
        issued[0]--;
        do_reset();

        // Reset during UPDATE (zero weights make target 0 a guaranteed mistake).
        send(0, 40, 30, 20, 10, 1'b1, 1'b0);
        n = 0;
        while (!(out_valid_a[0] && out_ready_a[0]) && n < 100) begin @(negedge clk); n++; end
        if (!(out_valid_a[0] && out_ready_a[0])) fail_now("update_wait_handshake");
        @(posedge clk); #1;
        chk("busy_update_in_ready", in_ready_a[0], 0);
        do_reset();
        send(0, 10, 20, -5, 3, 1'b0, 1'b0);
        wait_idle(0);

        // Randomized traffic on both instances.
        for (int k = 0; k < 60; k++) begin
            int d = (k % 3 == 2) ? 1 : 0;
            if ($urandom_range(0, 9) == 0) do_clear(d);
            send(d, rx(), rx(), rx(), rx(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle(d);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("d0_accept_count", accepts[0], issued[0]);
        chk("d1_accept_count", accepts[1], issued[1]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
